// File: rtl/tick_sequencer.sv
// Programmable tick-burst controller: reload-and-decrement divider issuing
// one-cycle pulses every period+1 clocks for a counted or continuous burst.
module tick_sequencer #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  period,
    input  logic [CWIDTH-1:0] count,
    output logic              pulse,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] remaining
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  period_s_q, period_s_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [CWIDTH-1:0] rem_q, rem_d;
    logic              counted_q, counted_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        period_s_d = period_s_q;
        div_d      = div_q;
        rem_d      = rem_q;
        counted_d  = counted_q;
        pulse_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    period_s_d = period;
                    div_d      = period;
                    rem_d      = count;
                    counted_d  = (count != '0);
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                end else if (div_q == '0) begin
                    pulse_d = 1'b1;
                    div_d   = period_s_q;
                    // Continuous mode keeps remaining at 0 and never completes.
                    if (counted_q) begin
                        rem_d = rem_q - CWIDTH'(1);
                        if (rem_q == CWIDTH'(1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q - WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            period_s_q <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            counted_q  <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_s_q <= period_s_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            counted_q  <= counted_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer; compares {pulse,busy,done,remaining}
// after each edge against hand-derived schedules.
module tb_tick_sequencer;

    localparam int WIDTH  = 16;
    localparam int CWIDTH = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start, stop;
    logic [WIDTH-1:0]  period;
    logic [CWIDTH-1:0] count;
    logic              pulse, busy, done;
    logic [CWIDTH-1:0] remaining;

    int n_cmp = 0;
    int n_err = 0;

    tick_sequencer #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .count     (count),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pk(input logic p, input logic b, input logic d, input int r);
        return {21'd0, p, b, d, r[7:0]};
    endfunction

    function automatic logic [31:0] obs();
        return {21'd0, pulse, busy, done, remaining};
    endfunction

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; period = '0; count = '0;
        #1;
        chk("reset_state", obs(), pk(0, 0, 0, 0));
        #10 reset_n = 1'b1;
        step();
        chk("idle_after_reset", obs(), pk(0, 0, 0, 0));

        // Scenario 1: period=4, count=3.
        start = 1'b1; period = 16'd4; count = 8'd3;
        step();
        start = 1'b0;
        chk("s1_e0", obs(), pk(0, 1, 0, 3));
        for (int e = 1; e <= 20; e++) begin
            step();
            chk($sformatf("s1_e%0d", e), obs(),
                pk(e == 5 || e == 10 || e == 15, e < 15, e == 15,
                   e < 5 ? 3 : e < 10 ? 2 : e < 15 ? 1 : 0));
        end

        // Scenario 2: continuous, period=2, stop at edge 10.
        start = 1'b1; period = 16'd2; count = 8'd0;
        step();
        start = 1'b0;
        chk("s2_e0", obs(), pk(0, 1, 0, 0));
        for (int e = 1; e <= 16; e++) begin
            stop = (e == 10);
            step();
            chk($sformatf("s2_e%0d", e), obs(),
                pk(e == 3 || e == 6 || e == 9, e < 10, 0, 0));
        end
        stop = 1'b0;

        // Scenario 3: period=0, count=4.
        start = 1'b1; period = 16'd0; count = 8'd4;
        step();
        start = 1'b0;
        chk("s3_e0", obs(), pk(0, 1, 0, 4));
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("s3_e%0d", e), obs(),
                pk(e <= 4, e < 4, e == 4, e <= 4 ? 4 - e : 0));
        end

        // Scenario 4: start while busy ignored; restart right after done.
        start = 1'b1; period = 16'd4; count = 8'd3;
        step();
        start = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            start = (e == 2);
            if (e == 2) begin period = 16'd1; count = 8'd9; end
            step();
            chk($sformatf("s4_e%0d", e), obs(),
                pk(e == 5 || e == 10 || e == 15, e < 15, e == 15,
                   e < 5 ? 3 : e < 10 ? 2 : e < 15 ? 1 : 0));
        end
        start = 1'b1; period = 16'd1; count = 8'd2;
        step();
        start = 1'b0;
        chk("s4_e16", obs(), pk(0, 1, 0, 2));
        for (int e = 17; e <= 22; e++) begin
            step();
            chk($sformatf("s4_e%0d", e), obs(),
                pk(e == 18 || e == 20, e < 20, e == 20,
                   e < 18 ? 2 : e < 20 ? 1 : 0));
        end

        // Scenario 5: asynchronous reset between edges 7 and 8.
        start = 1'b1; period = 16'd4; count = 8'd3;
        step();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        chk("s5_e5_pulse", obs(), pk(1, 1, 0, 2));
        step(); step();
        chk("s5_e7", obs(), pk(0, 1, 0, 2));
        #2 reset_n = 1'b0;
        #1;
        chk("s5_async_clear", obs(), pk(0, 0, 0, 0));
        #1 reset_n = 1'b1;
        for (int e = 8; e <= 20; e++) begin
            step();
            chk($sformatf("s5_e%0d", e), obs(), pk(0, 0, 0, 0));
        end

        // Scenario 6: start and stop together in IDLE.
        start = 1'b1; stop = 1'b1; period = 16'd0; count = 8'd5;
        step();
        start = 1'b0; stop = 1'b0;
        chk("s6_e0", obs(), pk(0, 0, 0, 0));
        for (int e = 1; e <= 20; e++) begin
            step();
            chk($sformatf("s6_e%0d", e), obs(), pk(0, 0, 0, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
Programmable tick-burst controller built on the same reload-and-decrement divider scheme as the fixed tick generators. On a start request it captures a period and a burst length, then issues one-cycle pulses every period+1 clocks until the burst completes or is aborted. It sits between a control FSM or user inputs and any logic that consumes tick pulses, replacing hard-wired fixed-rate tick modules wherever the rate or the number of ticks must be set at run time.

Parameters:
WIDTH, 16, bit width of the period input and the internal divider counter
CWIDTH, 8, bit width of the burst count input and the remaining output

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request to begin a burst; sampled only in IDLE
stop  input  1  abort the running burst; highest priority after reset
period  input  WIDTH  tick spacing minus one; captured on an accepted start
count  input  CWIDTH  number of pulses in the burst; 0 = continuous; captured on an accepted start
pulse  output  1  registered, one-cycle tick
busy  output  1  high while in RUN
done  output  1  one-cycle strobe when a counted burst completes normally
remaining  output  CWIDTH  pulses still to issue (0 in IDLE and in continuous mode)

Behaviour:
- States: IDLE, RUN. Reset (reset_n=0, asynchronous) forces IDLE, and pulse=0, busy=0, done=0, remaining=0, divider=0, shadow period=0.
- All outputs are registered; done and pulse are low on any edge that does not explicitly set them.
- IDLE, start=1, stop=0 at edge k: period_s<=period, divider<=period, remaining<=count, busy<=1, state<=RUN.
- IDLE with start=1 and stop=1: stop wins; the block stays in IDLE.
- RUN, each edge, stop=0:
  - divider==0: pulse<=1 and divider<=period_s.
    - Counted mode: remaining<=remaining-1. If remaining==1, also state<=IDLE, busy<=0, done<=1 on this same edge.
  - Otherwise: pulse<=0 and divider<=divider-1.
- Timing: the first pulse is high after edge k+period+1. Later pulses follow every period+1 cycles. period=0 gives a pulse every cycle starting at k+1.
- Continuous mode (count=0): remaining stays 0, done never asserts, and the block runs until stop or reset.
- RUN, stop=1: state<=IDLE, busy<=0, pulse<=0, done<=0, remaining<=0. Stop overrides a pulse that would fire on the same edge.
- start while busy is ignored: no reload and no restart. period and count are not sampled except on an accepted start.
- A start is accepted on the first edge after done, because the state is IDLE by then. A start asserted on the edge that issues the final pulse is ignored.
- Arithmetic: the divider only decrements from a nonzero value and remaining only decrements from a nonzero value in counted mode, so no wrap-around is possible. The maximum spacing is 2^WIDTH cycles.
- Reset mid-burst clears all outputs immediately. After release the block waits in IDLE for a fresh start.

Test Plan:
- period=4, count=3, start high for edge 0 -> pulse high after edges 5, 10, 15 only; remaining 3→2→1→0 at those edges; busy high after edges 0..14 and low after 15; done high only after edge 15.
- period=2, count=0, start at edge 0, stop at edge 10 -> pulses after edges 3, 6, 9; busy low after 10; no pulse and no done thereafter.
- period=0, count=4, start at edge 0 -> pulse high after edges 1, 2, 3, 4; done and busy=0 after edge 4.
- period=4, count=3 running; at edge 2 apply start with period=1, count=9 -> ignored, sequence is identical to scenario 1; a start at edge 16 is accepted with the new values.
- Burst running, reset_n pulled low between edges 7 and 8 -> pulse, busy, done and remaining go 0 without a clock edge; after release, no pulses until a new start.
- IDLE, start=1 and stop=1 on the same edge -> busy stays 0 and no pulse appears within 20 cycles.
